// File: rtl/instr_aligner_pkg.sv
// Shared types and defaults for the instruction aligner and the
// scanner-side consumers of aligned instructions.
package instr_aligner_pkg;

  // Default halfword buffer capacity. Must be at least 4 and even.
  localparam int INSTR_ALIGN_DEPTH_HW = 4;

  // One aligned instruction as handed to the scanner.
  typedef struct packed {
    logic [31:0] instr;
    logic [63:0] addr;
    logic        is_rvc;
  } aligned_instr_t;

  // Compressed-instruction test, identical to the scanner's rule.
  function automatic logic is_rvc_hw(input logic [15:0] hw);
    return hw[1:0] != 2'b11;
  endfunction

endpackage

// File: rtl/instr_aligner.sv
// Instruction aligner: buffers fetch halfwords in a shift register and
// presents one instruction per handshake, starting at bit 0, stitching
// 32-bit instructions that straddle two fetch words.
//
// Handshakes: a transfer happens on a rising edge where valid and ready
// are both high. fetch_ready_o depends only on the buffered count and
// flush_i; instr_valid_o depends only on buffered state and flush_i, so
// there is no combinational path from the fetch side to the instruction
// side. Both are low in a flush cycle.
module instr_aligner
  import instr_aligner_pkg::*;
#(
  parameter int DEPTH_HW = INSTR_ALIGN_DEPTH_HW
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        flush_i,
  input  logic        fetch_valid_i,
  output logic        fetch_ready_o,
  input  logic [31:0] fetch_data_i,
  input  logic [63:0] fetch_addr_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_o,
  output logic [63:0] instr_addr_o,
  output logic        instr_is_rvc_o
);

  localparam int CW = $clog2(DEPTH_HW + 1);

  logic [15:0]    hw_q   [DEPTH_HW];
  logic [15:0]    hw_d   [DEPTH_HW];
  logic [15:0]    hw_mid [DEPTH_HW];
  logic [15:0]    hw_ext [DEPTH_HW+2];
  logic [CW-1:0]  count_q, count_d, count_mid;
  logic [CW-1:0]  pop_n, push_n;
  logic [63:0]    head_addr_q, head_addr_d;
  logic [15:0]    first_hw;
  logic           head_rvc;
  logic           instr_fire, fetch_fire;
  aligned_instr_t out_instr;

  assign head_rvc = is_rvc_hw(hw_q[0]);

  // Ready ignores a same-cycle pop: room for a full word must already exist.
  assign fetch_ready_o = ~flush_i & (count_q <= CW'(DEPTH_HW - 2));

  // A 32-bit head needs both halves buffered before it is presented.
  assign instr_valid_o = ~flush_i & (count_q >= (head_rvc ? CW'(1) : CW'(2)));

  assign instr_fire = instr_valid_o & instr_ready_i;
  assign fetch_fire = fetch_valid_i & fetch_ready_o;

  // Build the outgoing instruction record from the head of the buffer.
  always_comb begin
    out_instr        = '0;
    out_instr.instr  = head_rvc ? {16'h0000, hw_q[0]} : {hw_q[1], hw_q[0]};
    out_instr.addr   = head_addr_q;
    out_instr.is_rvc = instr_valid_o & head_rvc;
  end

  assign instr_o        = out_instr.instr;
  assign instr_addr_o   = out_instr.addr;
  assign instr_is_rvc_o = out_instr.is_rvc;

  // Halfword counts removed and appended this cycle, and the resulting count.
  always_comb begin
    pop_n     = '0;
    push_n    = '0;
    if (instr_fire) pop_n  = head_rvc ? CW'(1) : CW'(2);
    if (fetch_fire) push_n = fetch_addr_i[1] ? CW'(1) : CW'(2);
    count_mid = count_q - pop_n;
    count_d   = count_mid + push_n;
  end

  // Shift out popped halfwords, then append the accepted fetch halfwords.
  always_comb begin
    first_hw = fetch_addr_i[1] ? fetch_data_i[31:16] : fetch_data_i[15:0];
    for (int i = 0; i < DEPTH_HW; i++) hw_ext[i] = hw_q[i];
    hw_ext[DEPTH_HW]   = '0;
    hw_ext[DEPTH_HW+1] = '0;
    for (int i = 0; i < DEPTH_HW; i++) begin
      case (pop_n)
        CW'(2):  hw_mid[i] = hw_ext[i+2];
        CW'(1):  hw_mid[i] = hw_ext[i+1];
        default: hw_mid[i] = hw_ext[i];
      endcase
    end
    for (int i = 0; i < DEPTH_HW; i++) begin
      hw_d[i] = hw_mid[i];
      if (fetch_fire && (CW'(i) == count_mid)) hw_d[i] = first_hw;
      if (fetch_fire && !fetch_addr_i[1] && (CW'(i) == count_mid + CW'(1)))
        hw_d[i] = fetch_data_i[31:16];
    end
  end

  // Head address advances past popped halfwords; an empty buffer restarts
  // at the address of the incoming fetch word.
  always_comb begin
    head_addr_d = head_addr_q + (64'(pop_n) << 1);
    if (fetch_fire && (count_mid == '0)) head_addr_d = fetch_addr_i;
  end

  // Buffer state: reset clears everything, flush empties but holds the address.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      count_q     <= '0;
      head_addr_q <= '0;
      for (int i = 0; i < DEPTH_HW; i++) hw_q[i] <= '0;
    end else if (flush_i) begin
      count_q <= '0;
    end else begin
      count_q     <= count_d;
      head_addr_q <= head_addr_d;
      for (int i = 0; i < DEPTH_HW; i++) hw_q[i] <= hw_d[i];
    end
  end

endmodule

// File: doc/instr_aligner.md
# instr_aligner

Frontend stage between the instruction-fetch response and the instruction scanner. It takes 32-bit fetch words, which may contain a mix of 16-bit (RVC) and 32-bit instructions at any halfword alignment. It buffers halfwords and emits exactly one aligned instruction per handshake, with its address, so the scanner always sees an instruction starting at bit 0. It also stitches 32-bit instructions that straddle two fetch words.

## Interface
Parameters:
- DEPTH_HW, 4: halfword buffer capacity; must be ≥ 4 and even.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, synchronous, active-low
- flush_i  in  1  discard all buffered halfwords (redirect)
- fetch_valid_i  in  1  fetch word valid
- fetch_ready_o  out  1  aligner can accept a fetch word
- fetch_data_i  in  32  word read from address {fetch_addr_i[63:2],2'b00}
- fetch_addr_i  in  64  address of first useful halfword; bit 0 always 0; bit 1 set means the lower halfword is discarded
- instr_valid_o  out  1  aligned instruction available
- instr_ready_i  in  1  downstream (scanner/decode) consumes instruction
- instr_o  out  32  aligned instruction; RVC is zero-extended ({16'h0,hw})
- instr_addr_o  out  64  address of instr_o
- instr_is_rvc_o  out  1  instr_o[1:0] != 2'b11

## Operation
State:
- halfword array hw[DEPTH_HW]
- count, 0..DEPTH_HW
- head_addr, 64 bit

Push:
- Accept on fetch_valid_i & fetch_ready_o.
- fetch_addr_i[1]=0: append lower then upper halfword (+2).
- fetch_addr_i[1]=1: append upper halfword only (+1).

Ready and head address:
- fetch_ready_o = ~flush_i & (DEPTH_HW − count ≥ 2). It is computed from current count and ignores a same-cycle pop.
- Halfwords in the buffer are contiguous. fetch_addr_i is used only when the buffer is empty after this cycle's pop. In that case head_addr ← fetch_addr_i.
- A non-contiguous fetch while count > 0 is an upstream protocol error. Upstream must flush first.

Emit:
- Head halfword hw[0] RVC (hw[0][1:0] != 2'b11): valid when count ≥ 1. instr_o = {16'h0, hw[0]}.
- Otherwise: valid when count ≥ 2. instr_o = {hw[1], hw[0]}.
- A 32-bit instruction with only one halfword buffered stalls (instr_valid_o = 0) until its upper half arrives.
- instr_valid_o is forced to 0 while flush_i = 1.

Pop:
- On instr_valid_o & instr_ready_i, remove 1 (RVC) or 2 halfwords.
- head_addr += 2 or 4 (64-bit wrap).
- Remaining halfwords shift to index 0.

Count update and priority:
- count_next = count + push_n − pop_n. Push and pop in the same cycle are allowed.
- Priority: rst_ni low > flush_i > push/pop.
- Flush: count ← 0 and head_addr is held. A fetch word presented in the flush cycle is not accepted, because ready is 0.

Reset:
- count = 0, head_addr = 0, hw = 0.
- Outputs after reset: instr_valid_o = 0, instr_o = 0, instr_addr_o = 0, instr_is_rvc_o = 0 (hw zero ⇒ RVC, gated by valid; all-zero output), fetch_ready_o = 1.
- Reset mid-operation drops the buffer in the reset edge.

## Timing
- Outputs are combinational from registered state; there is no combinational path from fetch_* to instr_*.
- Latency: fetch word accepted at edge N → first instruction valid in cycle N+1.
- Straddling 32-bit instruction: valid the cycle after the second word is accepted.
- fetch_ready_o depends on count and flush_i only. instr_valid_o depends on state and flush_i only.
- Throughput: with DEPTH_HW = 4 and RVC-dense code, the aligner emits 1 per cycle and accepts a word every 2 cycles. With 32-bit code it sustains 1 word per cycle in and 1 instruction per cycle out.

## Structure
- Add to ariane_pkg:
  - INSTR_ALIGN_DEPTH_HW default constant
  - typedef aligned_instr_t {instr[31:0], addr[63:0], is_rvc}, used by instr_aligner and instr_scan consumers
- RVC test: same `instr[1:0] != 2'b11` rule the scanner uses; a local expression, no sub-module instance.
- Single module; buffer is a shift register of halfwords. No sub-module is needed.

## Test plan
- Reset, then push 0x0001_4501 at addr 0x8000_0000 (two RVC) → out 0x0000_4501 @0x8000_0000, then 0x0000_0001 @0x8000_0002; count returns to 0.
- Push 0x0000_0513 at 0x1000, then 0x0000_0593 at 0x1004, with ready held high → 0x0000_0513 @0x1000 in cycle N+1 and 0x0000_0593 @0x1004 next; no bubbles.
- Straddle:
  - Push 0x0513_4501 at 0x2000 → RVC 0x4501 @0x2000 emitted. Upper halfword 0x0513 is a 32-bit low half, so instr_valid_o = 0.
  - Push 0x1234_0000 at 0x2004 → 0x0000_0513 @0x2002. The next halfword 0x1234 has bits[1:0] = 00, so it is RVC → 0x0000_1234 @0x2006.
- Misaligned entry: push 0xABCD_4501 at 0x3002 → only 0x0000_ABCD consumed. If RVC (it is, bits = 01): emitted @0x3002.
- Backpressure: hold instr_ready_i = 0 and push 32-bit words → fetch_ready_o drops to 0 once count = 4 (after 2 words); outputs stay stable.
- Flush with count = 3 while fetch_valid_i = 1 → that word is not accepted, instr_valid_o = 0 in the flush cycle, count = 0 next cycle. A following push at 0x4000 gives head addr 0x4000.
